// File: rtl/uart_tx_on_press.sv
// Press-triggered 8N1 UART transmitter: one frame of data_in per rising edge
// of the debounced button. Presses during a frame are dropped, not queued.
module uart_tx_on_press #(
    parameter int CLK_FREQ     = 50_000_000,
    parameter int BAUD         = 9600,
    parameter int CLKS_PER_BIT = CLK_FREQ / BAUD
) (
    input  logic       clk,
    input  logic       rst_a_p,
    input  logic       btn_db,
    input  logic [7:0] data_in,
    output logic       tx,
    output logic       busy,
    output logic       done
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shreg_q, shreg_d;
    logic             btn_prev_q;
    logic             tx_q, tx_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             press;
    logic             bit_end;

    assign press   = btn_db & ~btn_prev_q;
    assign bit_end = (cnt_q == CNT_LAST);

    // tx_d/busy_d describe the line after the coming edge, so the outputs
    // are registered yet change on the same edge as the state.
    always_comb begin
        // NOTE: every target gets a default first so no path can infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shreg_d = shreg_q;
        tx_d    = tx_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (press) begin
                    shreg_d = data_in;
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = S_START;
                    tx_d    = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            S_START: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = S_DATA;
                    tx_d    = shreg_q[0];
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    shreg_d = {1'b0, shreg_q[7:1]};
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        state_d = S_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        tx_d = shreg_q[1];
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                    tx_d    = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // btn_prev resets high so a button held through reset is not a press.
    always_ff @(posedge clk or posedge rst_a_p) begin
        if (rst_a_p) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            shreg_q    <= '0;
            btn_prev_q <= 1'b1;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            shreg_q    <= shreg_d;
            btn_prev_q <= btn_db;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign tx   = tx_q;
    assign busy = busy_q;
    assign done = done_q;
endmodule

// File: tb/tb_uart_tx_on_press.sv
// Self-checking bench for uart_tx_on_press with CLKS_PER_BIT = 16; a frame-level
// reference model predicts tx/busy/done after every clock edge.
module tb_uart_tx_on_press;
    localparam int CPB = 16;

    logic       clk     = 1'b0;
    logic       rst_a_p = 1'b0;
    logic       btn_db  = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       tx, busy, done;

    int checks = 0;
    int errors = 0;

    // Reference model: a frame is just "age since the press edge".
    logic       m_prev, m_active;
    int         m_age;
    logic [7:0] m_byte;
    logic       exp_tx, exp_busy, exp_done;

    uart_tx_on_press #(.CLK_FREQ(16), .BAUD(1)) dut (
        .clk     (clk),
        .rst_a_p (rst_a_p),
        .btn_db  (btn_db),
        .data_in (data_in),
        .tx      (tx),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    function automatic logic line_bit(input logic [7:0] b, input int n);
        if (n == 0) return 1'b0;
        if (n <= 8) return b[n-1];
        return 1'b1;
    endfunction

    always @(posedge clk or posedge rst_a_p) begin
        if (rst_a_p) begin
            m_prev   <= 1'b1;
            m_active <= 1'b0;
            m_age    <= 0;
            m_byte   <= 8'h00;
            exp_tx   <= 1'b1;
            exp_busy <= 1'b0;
            exp_done <= 1'b0;
        end else begin
            m_prev   <= btn_db;
            exp_done <= 1'b0;
            if (m_active) begin
                if (m_age + 1 == 10 * CPB) begin
                    m_active <= 1'b0;
                    exp_tx   <= 1'b1;
                    exp_busy <= 1'b0;
                    exp_done <= 1'b1;
                end else begin
                    m_age    <= m_age + 1;
                    exp_tx   <= line_bit(m_byte, (m_age + 1) / CPB);
                    exp_busy <= 1'b1;
                end
            end else if (btn_db && !m_prev) begin
                m_active <= 1'b1;
                m_age    <= 0;
                m_byte   <= data_in;
                exp_tx   <= 1'b0;
                exp_busy <= 1'b1;
            end else begin
                exp_tx   <= 1'b1;
                exp_busy <= 1'b0;
            end
        end
    end

    task automatic test_reset();
        #2 rst_a_p = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({tx, busy, done} !== 3'b100) begin
                errors++;
                $display("FAIL reset_values i=%0d tx/busy/done got %b%b%b want 100", i, tx, busy, done);
            end
        end
        rst_a_p = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if ({tx, busy, done} !== {exp_tx, exp_busy, exp_done}) begin
                errors++;
                $display("FAIL reset_idle i=%0d got %b%b%b want %b%b%b", i, tx, busy, done, exp_tx, exp_busy, exp_done);
            end
        end
    endtask

    task automatic test_basic();
        logic [9:0] seq;
        int off;
        int ndone;
        seq   = 10'b1101001010;
        ndone = 0;
        for (int i = 0; i < 180; i++) begin
            @(negedge clk);
            off = i - 3;
            if (done) ndone++;
            checks++;
            if ({tx, busy, done} !== {exp_tx, exp_busy, exp_done}) begin
                errors++;
                $display("FAIL basic_model off=%0d got %b%b%b want %b%b%b", off, tx, busy, done, exp_tx, exp_busy, exp_done);
            end
            if (off >= 0 && off < 160 && off % 16 == 8) begin
                checks++;
                if (tx !== seq[off/16]) begin
                    errors++;
                    $display("FAIL basic_bit n=%0d tx got %b want %b", off / 16, tx, seq[off/16]);
                end
            end
            if (off >= 0 && off <= 160) begin
                checks++;
                if (busy !== (off < 160) || done !== (off == 160)) begin
                    errors++;
                    $display("FAIL basic_busy_done off=%0d got busy=%b done=%b", off, busy, done);
                end
            end
            btn_db  = (i == 2);
            data_in = 8'hA5;
        end
        checks++;
        if (ndone != 1) begin
            errors++;
            $display("FAIL basic_done_count got %0d want 1", ndone);
        end
    endtask

    task automatic test_busy_press();
        int off;
        int ndone;
        ndone = 0;
        for (int i = 0; i < 220; i++) begin
            @(negedge clk);
            off = i - 3;
            if (done) ndone++;
            checks++;
            if ({tx, busy, done} !== {exp_tx, exp_busy, exp_done}) begin
                errors++;
                $display("FAIL busy_press_model off=%0d got %b%b%b want %b%b%b", off, tx, busy, done, exp_tx, exp_busy, exp_done);
            end
            if (off >= 160) begin
                checks++;
                if (tx !== 1'b1 || busy !== 1'b0) begin
                    errors++;
                    $display("FAIL busy_press_idle off=%0d got tx=%b busy=%b want tx=1 busy=0", off, tx, busy);
                end
            end
            btn_db  = (i == 2 || i == 42 || i == 161);
            data_in = 8'h3C;
        end
        checks++;
        if (ndone != 1) begin
            errors++;
            $display("FAIL busy_press_done_count got %0d want 1", ndone);
        end
    endtask

    task automatic test_held();
        int off;
        int ndone;
        ndone = 0;
        for (int i = 0; i < 700; i++) begin
            @(negedge clk);
            off = i - 3;
            if (done) ndone++;
            checks++;
            if ({tx, busy, done} !== {exp_tx, exp_busy, exp_done}) begin
                errors++;
                $display("FAIL held_model off=%0d got %b%b%b want %b%b%b", off, tx, busy, done, exp_tx, exp_busy, exp_done);
            end
            if (off >= 16 && off < 144 && off % 16 == 8) begin
                checks++;
                if (tx !== (off / 16 <= 4)) begin
                    errors++;
                    $display("FAIL held_capture n=%0d tx got %b want %b", off / 16, tx, (off / 16 <= 4));
                end
            end
            btn_db  = (i >= 2 && i < 502);
            data_in = (off >= 20) ? 8'hF0 : 8'h0F;
        end
        checks++;
        if (ndone != 1) begin
            errors++;
            $display("FAIL held_done_count got %0d want 1", ndone);
        end
    endtask

    task automatic test_back_to_back();
        int off;
        int ndone;
        ndone = 0;
        for (int i = 0; i < 345; i++) begin
            @(negedge clk);
            off = i - 3;
            if (done) ndone++;
            checks++;
            if ({tx, busy, done} !== {exp_tx, exp_busy, exp_done}) begin
                errors++;
                $display("FAIL b2b_model off=%0d got %b%b%b want %b%b%b", off, tx, busy, done, exp_tx, exp_busy, exp_done);
            end
            if (off == 160) begin
                checks++;
                if ({tx, busy, done} !== 3'b101) begin
                    errors++;
                    $display("FAIL b2b_end1 got %b%b%b want 101", tx, busy, done);
                end
            end
            if (off == 161) begin
                checks++;
                if ({tx, busy, done} !== 3'b010) begin
                    errors++;
                    $display("FAIL b2b_start2 got %b%b%b want 010", tx, busy, done);
                end
            end
            if (off >= 16 && off < 144 && off % 16 == 8) begin
                checks++;
                if (tx !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_data1 off=%0d tx got %b want 0", off, tx);
                end
            end
            if (off >= 177 && off < 305 && (off - 161) % 16 == 8) begin
                checks++;
                if (tx !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_data2 off=%0d tx got %b want 1", off, tx);
                end
            end
            btn_db  = (i == 2 || i == 163);
            data_in = (i >= 100) ? 8'hFF : 8'h00;
        end
        checks++;
        if (ndone != 2) begin
            errors++;
            $display("FAIL b2b_done_count got %0d want 2", ndone);
        end
    endtask

    task automatic test_reset_mid();
        int ndone;
        ndone = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            checks++;
            if ({tx, busy, done} !== {exp_tx, exp_busy, exp_done}) begin
                errors++;
                $display("FAIL reset_mid_model i=%0d got %b%b%b want %b%b%b", i, tx, busy, done, exp_tx, exp_busy, exp_done);
            end
            btn_db  = (i == 2);
            data_in = 8'h00;
        end
        @(negedge clk);
        #1 rst_a_p = 1'b1;
        #1;
        checks++;
        if ({tx, busy, done} !== 3'b100) begin
            errors++;
            $display("FAIL reset_mid_async got tx/busy/done %b%b%b want 100", tx, busy, done);
        end
        @(negedge clk);
        rst_a_p = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (done) ndone++;
            checks++;
            if ({tx, busy, done} !== {exp_tx, exp_busy, exp_done}) begin
                errors++;
                $display("FAIL reset_mid_after i=%0d got %b%b%b want %b%b%b", i, tx, busy, done, exp_tx, exp_busy, exp_done);
            end
        end
        checks++;
        if (ndone != 0) begin
            errors++;
            $display("FAIL reset_mid_no_done got %0d want 0", ndone);
        end
    endtask

    task automatic test_reset_held();
        int ndone;
        ndone = 0;
        @(negedge clk);
        rst_a_p = 1'b1;
        btn_db  = 1'b1;
        data_in = 8'h5A;
        @(negedge clk);
        rst_a_p = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (done) ndone++;
            checks++;
            if ({tx, busy, done} !== {exp_tx, exp_busy, exp_done}) begin
                errors++;
                $display("FAIL reset_held_model i=%0d got %b%b%b want %b%b%b", i, tx, busy, done, exp_tx, exp_busy, exp_done);
            end
            if (i < 100) begin
                checks++;
                if (busy !== 1'b0 || tx !== 1'b1) begin
                    errors++;
                    $display("FAIL reset_held_no_frame i=%0d got tx=%b busy=%b want tx=1 busy=0", i, tx, busy);
                end
            end
            btn_db = !(i >= 100 && i < 110);
        end
        checks++;
        if (ndone != 1) begin
            errors++;
            $display("FAIL reset_held_done_count got %0d want 1", ndone);
        end
        btn_db = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            checks++;
            if ({tx, busy, done} !== {exp_tx, exp_busy, exp_done}) begin
                errors++;
                $display("FAIL random_model i=%0d got %b%b%b want %b%b%b", i, tx, busy, done, exp_tx, exp_busy, exp_done);
            end
            if ($urandom_range(0, 39) == 0) btn_db = ~btn_db;
            data_in = 8'($urandom);
        end
        btn_db = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_busy_press();
        test_held();
        test_back_to_back();
        test_reset_mid();
        test_reset_held();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
